// File: rtl/fd_compara_tiros_e_asteroides_pkg.sv
// Shared constants for the shot/asteroid comparison datapath: default sizes,
// renderizado flag encoding and the index-width helper.
package fd_compara_tiros_e_asteroides_pkg;

  localparam int N_TIROS_DEF      = 4;
  localparam int N_ASTEROIDES_DEF = 8;
  localparam int POS_W_DEF        = 8;
  localparam int PONTOS_W_DEF     = 8;

  localparam logic RENDERIZADO = 1'b1;
  localparam logic DESTRUIDO   = 1'b0;

  // Index width for a bank of n slots; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_TIROS_W      = idx_w(N_TIROS_DEF);
  localparam int IDX_ASTEROIDES_W = idx_w(N_ASTEROIDES_DEF);

endpackage

// File: rtl/fd_compara_tiros_e_asteroides_if.sv
// Command/status bundle between the control unit plus game engine (master)
// and the comparison datapath (slave). Plain level signals, no handshake.
interface fd_compara_tiros_e_asteroides_if
  import fd_compara_tiros_e_asteroides_pkg::*;
#(
  parameter int N_TIROS      = N_TIROS_DEF,
  parameter int N_ASTEROIDES = N_ASTEROIDES_DEF,
  parameter int POS_W        = POS_W_DEF,
  parameter int PONTOS_W     = PONTOS_W_DEF
);

  localparam int IT_W = idx_w(N_TIROS);
  localparam int IA_W = idx_w(N_ASTEROIDES);

  // Control unit commands
  logic reset_contador_tiros;
  logic reset_contador_asteroides;
  logic conta_contador_tiros;
  logic conta_contador_asteroides;
  logic enable_load_tiro;
  logic enable_load_asteroide;
  logic loaded_tiro;
  logic loaded_asteroide;

  // Game engine write ports
  logic             escreve_tiro;
  logic [IT_W-1:0]  indice_tiro_ext;
  logic [POS_W-1:0] posicao_tiro_ext;
  logic             renderizado_tiro_ext;
  logic             escreve_asteroide;
  logic [IA_W-1:0]  indice_asteroide_ext;
  logic [POS_W-1:0] posicao_asteroide_ext;
  logic             renderizado_asteroide_ext;

  // Status back to the control unit and score logic
  logic                tiro_renderizado;
  logic                aste_renderizado;
  logic                posicao_tiro_igual_asteroide;
  logic                rco_contador_tiros;
  logic                rco_contador_asteroides;
  logic [PONTOS_W-1:0] asteroides_destruidos;
  logic [IT_W-1:0]     db_contador_tiros;
  logic [IA_W-1:0]     db_contador_asteroides;

  modport master (
    output reset_contador_tiros, reset_contador_asteroides,
           conta_contador_tiros, conta_contador_asteroides,
           enable_load_tiro, enable_load_asteroide,
           loaded_tiro, loaded_asteroide,
           escreve_tiro, indice_tiro_ext, posicao_tiro_ext, renderizado_tiro_ext,
           escreve_asteroide, indice_asteroide_ext, posicao_asteroide_ext,
           renderizado_asteroide_ext,
    input  tiro_renderizado, aste_renderizado, posicao_tiro_igual_asteroide,
           rco_contador_tiros, rco_contador_asteroides, asteroides_destruidos,
           db_contador_tiros, db_contador_asteroides
  );

  modport slave (
    input  reset_contador_tiros, reset_contador_asteroides,
           conta_contador_tiros, conta_contador_asteroides,
           enable_load_tiro, enable_load_asteroide,
           loaded_tiro, loaded_asteroide,
           escreve_tiro, indice_tiro_ext, posicao_tiro_ext, renderizado_tiro_ext,
           escreve_asteroide, indice_asteroide_ext, posicao_asteroide_ext,
           renderizado_asteroide_ext,
    output tiro_renderizado, aste_renderizado, posicao_tiro_igual_asteroide,
           rco_contador_tiros, rco_contador_asteroides, asteroides_destruidos,
           db_contador_tiros, db_contador_asteroides
  );

endinterface

// File: rtl/fd_compara_tiros_e_asteroides_banco_objetos.sv
// One object bank: position and renderizado arrays, a wrapping index counter
// and the two write ports (engine write by index, destruction load at index).
module banco_objetos
  import fd_compara_tiros_e_asteroides_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int POS_W = 8,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             reset_contador_i,
  input  logic             conta_i,
  input  logic             enable_load_i,
  input  logic             loaded_i,
  input  logic             escreve_i,
  input  logic [IDX_W-1:0] indice_ext_i,
  input  logic [POS_W-1:0] posicao_ext_i,
  input  logic             renderizado_ext_i,
  output logic [IDX_W-1:0] indice_o,
  output logic [POS_W-1:0] posicao_o,
  output logic             renderizado_o,
  output logic             rco_o
);

  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(DEPTH - 1);

  logic [POS_W-1:0] posicao_q [DEPTH];
  logic [POS_W-1:0] posicao_d [DEPTH];
  logic [DEPTH-1:0] renderizado_q, renderizado_d;
  logic [IDX_W-1:0] indice_q, indice_d;

  always_comb begin
    posicao_d     = posicao_q;
    renderizado_d = renderizado_q;
    indice_d      = indice_q;

    if (escreve_i) begin
      posicao_d[indice_ext_i]     = posicao_ext_i;
      renderizado_d[indice_ext_i] = renderizado_ext_i;
    end

    // Applied after the engine write so destruction wins on a shared slot;
    // addressed by the pre-count index.
    if (enable_load_i) begin
      renderizado_d[indice_q] = loaded_i;
    end

    if (reset_contador_i) begin
      indice_d = '0;
    end else if (conta_i) begin
      indice_d = (indice_q == ULTIMO) ? '0 : indice_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        posicao_q[i] <= '0;
      end
      renderizado_q <= '0;
      indice_q      <= '0;
    end else begin
      posicao_q     <= posicao_d;
      renderizado_q <= renderizado_d;
      indice_q      <= indice_d;
    end
  end

  assign indice_o      = indice_q;
  assign posicao_o     = posicao_q[indice_q];
  assign renderizado_o = renderizado_q[indice_q];
  assign rco_o         = (indice_q == ULTIMO);

endmodule

// File: rtl/fd_compara_tiros_e_asteroides.sv
// Shot/asteroid comparison datapath: two object banks, the position
// comparator and the saturating destroyed-asteroid counter.
module fd_compara_tiros_e_asteroides
  import fd_compara_tiros_e_asteroides_pkg::*;
#(
  parameter int N_TIROS      = N_TIROS_DEF,
  parameter int N_ASTEROIDES = N_ASTEROIDES_DEF,
  parameter int POS_W        = POS_W_DEF,
  parameter int PONTOS_W     = PONTOS_W_DEF
) (
  input logic clock,
  input logic reset,
  fd_compara_tiros_e_asteroides_if.slave bus
);

  localparam int IT_W = idx_w(N_TIROS);
  localparam int IA_W = idx_w(N_ASTEROIDES);

  logic [POS_W-1:0] posicao_tiro;
  logic [POS_W-1:0] posicao_asteroide;
  logic             aste_renderizado;
  logic [IT_W-1:0]  indice_tiro;
  logic [IA_W-1:0]  indice_asteroide;

  banco_objetos #(
    .DEPTH (N_TIROS),
    .POS_W (POS_W),
    .IDX_W (IT_W)
  ) u_tiros (
    .clk_i             (clock),
    .rst_i             (reset),
    .reset_contador_i  (bus.reset_contador_tiros),
    .conta_i           (bus.conta_contador_tiros),
    .enable_load_i     (bus.enable_load_tiro),
    .loaded_i          (bus.loaded_tiro),
    .escreve_i         (bus.escreve_tiro),
    .indice_ext_i      (bus.indice_tiro_ext),
    .posicao_ext_i     (bus.posicao_tiro_ext),
    .renderizado_ext_i (bus.renderizado_tiro_ext),
    .indice_o          (indice_tiro),
    .posicao_o         (posicao_tiro),
    .renderizado_o     (bus.tiro_renderizado),
    .rco_o             (bus.rco_contador_tiros)
  );

  banco_objetos #(
    .DEPTH (N_ASTEROIDES),
    .POS_W (POS_W),
    .IDX_W (IA_W)
  ) u_asteroides (
    .clk_i             (clock),
    .rst_i             (reset),
    .reset_contador_i  (bus.reset_contador_asteroides),
    .conta_i           (bus.conta_contador_asteroides),
    .enable_load_i     (bus.enable_load_asteroide),
    .loaded_i          (bus.loaded_asteroide),
    .escreve_i         (bus.escreve_asteroide),
    .indice_ext_i      (bus.indice_asteroide_ext),
    .posicao_ext_i     (bus.posicao_asteroide_ext),
    .renderizado_ext_i (bus.renderizado_asteroide_ext),
    .indice_o          (indice_asteroide),
    .posicao_o         (posicao_asteroide),
    .renderizado_o     (aste_renderizado),
    .rco_o             (bus.rco_contador_asteroides)
  );

  logic [PONTOS_W-1:0] destruidos_q, destruidos_d;
  logic                conta_destruicao;

  // Only a live asteroid turning into a destroyed one scores.
  always_comb begin
    conta_destruicao = bus.enable_load_asteroide &&
                       (bus.loaded_asteroide == DESTRUIDO) &&
                       (aste_renderizado == RENDERIZADO);
    destruidos_d = destruidos_q;
    if (conta_destruicao && (destruidos_q != {PONTOS_W{1'b1}})) begin
      destruidos_d = destruidos_q + PONTOS_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      destruidos_q <= '0;
    end else begin
      destruidos_q <= destruidos_d;
    end
  end

  assign bus.aste_renderizado             = aste_renderizado;
  assign bus.posicao_tiro_igual_asteroide = (posicao_tiro == posicao_asteroide);
  assign bus.asteroides_destruidos        = destruidos_q;
  assign bus.db_contador_tiros            = indice_tiro;
  assign bus.db_contador_asteroides       = indice_asteroide;

endmodule

// File: doc/fd_compara_tiros_e_asteroides.md
Name: fd_compara_tiros_e_asteroides

Overview:
Datapath responder for the tiro/asteroide comparison control unit. Holds the shot and asteroid register banks (position plus renderizado flag) and the two index counters. Executes the unit's reset/count/load commands and returns these status signals: renderizado flags, RCOs and position equality.
Also accepts spawn/move writes from the game engine and keeps a saturating destroyed-asteroid counter for the score logic.

Parameters:
N_TIROS, 4, number of shot slots (power of 2, >=2)
N_ASTEROIDES, 8, number of asteroid slots (power of 2, >=2)
POS_W, 8, position width ({x[3:0], y[3:0]} by default)
PONTOS_W, 8, destroyed-counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; clears all state
reset_contador_tiros  in  1  zero shot index
reset_contador_asteroides  in  1  zero asteroid index
conta_contador_tiros  in  1  increment shot index
conta_contador_asteroides  in  1  increment asteroid index
enable_load_tiro  in  1  write loaded_tiro into renderizado[shot index]
enable_load_asteroide  in  1  write loaded_asteroide into renderizado[aste index]
loaded_tiro  in  1  value written to shot renderizado flag
loaded_asteroide  in  1  value written to asteroid renderizado flag
escreve_tiro  in  1  engine write strobe, shot bank
indice_tiro_ext  in  clog2(N_TIROS)  engine write index
posicao_tiro_ext  in  POS_W  engine write position
renderizado_tiro_ext  in  1  engine write flag
escreve_asteroide  in  1  engine write strobe, asteroid bank
indice_asteroide_ext  in  clog2(N_ASTEROIDES)  engine write index
posicao_asteroide_ext  in  POS_W  engine write position
renderizado_asteroide_ext  in  1  engine write flag
tiro_renderizado  out  1  renderizado[shot index]
aste_renderizado  out  1  renderizado[aste index]
posicao_tiro_igual_asteroide  out  1  pos_tiro[shot idx] == pos_aste[aste idx]
rco_contador_tiros  out  1  shot index == N_TIROS-1
rco_contador_asteroides  out  1  aste index == N_ASTEROIDES-1
asteroides_destruidos  out  PONTOS_W  saturating destroyed count
db_contador_tiros  out  clog2(N_TIROS)  debug index
db_contador_asteroides  out  clog2(N_ASTEROIDES)  debug index

Behaviour:
- Reset (synchronous, active-high): both indices 0, all positions 0, all renderizado flags 0, asteroides_destruidos 0. Resulting outputs: tiro_renderizado=0, aste_renderizado=0, posicao_tiro_igual_asteroide=1 (0==0), rco outputs 0.
- Counters: each counter updates on the clock edge. reset_contador_x beats conta_contador_x. At N-1, a count wraps to 0. The two counters are independent: reset of one and count of the other in the same cycle both take effect.
- All outputs are combinational reads of the current registers, valid in the cycle after the command edge. This matches the control unit's auxiliar states and requires no extra latency.
- Destruction write: enable_load_tiro writes loaded_tiro into renderizado[shot index]. enable_load_asteroide writes loaded_asteroide into renderizado[aste index]. Both use the index as it stands before any same-cycle count.
- asteroides_destruidos increments by 1 when enable_load_asteroide=1, loaded_asteroide=0 and the addressed asteroid flag is currently 1. It saturates at all-ones. Clearing an already-clear flag does not count.
- Engine write: escreve_x writes both position and flag at indice_x_ext.
- Same slot, same cycle, engine write plus enable_load: position takes the engine value; the renderizado flag takes the destruction value, so destruction wins.
- Engine writes to other slots proceed concurrently with comparison.
- No FSM in this block; sequencing belongs to the control unit. Commands arriving while reset=1 are ignored.

Decomposition:
- Shared package: index widths via clog2, POS_W, and the flag-encoding constants RENDERIZADO=1 and DESTRUIDO=0.
- One sub-module: banco_objetos. It is parameterised by depth and POS_W, and contains a position array, a flag array, an index counter with reset/count/rco, the engine write port and the load port. It is instantiated twice: once for shots, once for asteroids.
- The comparator and the destroyed counter live in the top module.

Test Plan:
- Reset, then idle → both indices 0, both flags 0, posicao_tiro_igual_asteroide=1, asteroides_destruidos=0.
- Engine writes tiro[2]=0x35 with flag 1 and asteroide[5]=0x35 with flag 1; then reset both counters, count tiros twice, count asteroids five times → tiro_renderizado=1, aste_renderizado=1, posicao_tiro_igual_asteroide=1.
- From that state, pulse enable_load_tiro and enable_load_asteroide with loaded=0 → both flags read 0 on the next cycle, asteroides_destruidos=1. Repeat the pulse → count stays 1.
- Count asteroid index from 7 → wraps to 0, rco_contador_asteroides goes 1 then 0. Assert reset_contador and conta together → index 0.
- In the same cycle on asteroide[3], engine write (0x12, flag 1) plus enable_load_asteroide with loaded 0 → position 0x12, flag 0.
- Preload the destroyed counter to 0xFF via repeated destructions, then destroy once more → stays 0xFF.
